slope_trigger: RTL

Event detector that sits directly downstream of the moving-difference stage. Consumes the current sample and its 8-bit slope, compares the slope against programmable hysteresis thresholds, and emits one timestamped event record per detected rising edge on an AXI-Stream master. A small FIFO buffers the records, so short output back-pressure does not lose events.

---
 rtl/slope_trigger_pkg.sv | 44 ++++
 rtl/slope_trigger_fifo.sv | 61 ++++++
 rtl/slope_trigger.sv | 104 ++++++++++
 3 files changed

// File: rtl/slope_trigger_pkg.sv
// Shared types and record layout for the slope trigger.
// SLOPE_TRIGGER_NEG_EN adds the saturating-negate helper used for falling-edge detection.
package slope_trigger_pkg;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    HOLD  = 2'd1,
    REARM = 2'd2
  } trig_state_e;

  localparam int REC_W     = 32;
  localparam int POL_BIT   = 31;
  localparam int TS_LSB    = 16;
  localparam int TS_W      = 15;
  localparam int SIG_LSB   = 8;
  localparam int SIG_W     = 8;
  localparam int SLOPE_LSB = 0;
  localparam int SLOPE_W   = 8;

  typedef struct packed {
    logic               pol;
    logic [TS_W-1:0]    ts;
    logic [SIG_W-1:0]   sig;
    logic [SLOPE_W-1:0] slope;
  } event_t;

  function automatic logic [REC_W-1:0] pack_event(input event_t ev);
    logic [REC_W-1:0] r;
    r                        = '0;
    r[POL_BIT]               = ev.pol;
    r[TS_LSB +: TS_W]        = ev.ts;
    r[SIG_LSB +: SIG_W]      = ev.sig;
    r[SLOPE_LSB +: SLOPE_W]  = ev.slope;
    return r;
  endfunction

`ifdef SLOPE_TRIGGER_NEG_EN
  // -(-128) does not fit in 8 bits; clamp to +127.
  function automatic logic signed [7:0] sat_neg(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sh7F : -v;
  endfunction
`endif

endpackage

// File: rtl/slope_trigger_fifo.sv
// Event record FIFO with a registered head word; drives the AXI-Stream master side.
// Storage holds DEPTH entries; the head register mirrors the oldest entry.
module slope_trigger_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] tdata,
  output logic         tvalid,
  input  logic         tready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count, count_n;
  logic          pop, push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = tvalid & tready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_comb begin
    count_n = count;
    if (push_ok && !pop)      count_n = count + (AW+1)'(1);
    else if (!push_ok && pop) count_n = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tvalid <= 1'b0;
      tdata  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_nxt;
      count  <= count_n;
      tvalid <= (count_n != '0);
      if (pop && count > (AW+1)'(1))
        tdata <= mem[rd_nxt];
      else if (push_ok && (empty || (pop && count == (AW+1)'(1))))
        tdata <= din;
    end
  end

endmodule

// File: rtl/slope_trigger.sv
// Slope hysteresis trigger: emits one timestamped record per detected edge via a small FIFO.
// Define SLOPE_TRIGGER_NEG_EN to also detect falling edges (polarity bit = 1).
module slope_trigger #(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 15
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        sample_valid,
  input  logic [7:0]  signal,
  input  logic [7:0]  signal_d,
  input  logic [7:0]  thr_hi,
  input  logic [7:0]  thr_lo,
  input  logic [15:0] holdoff,
  input  logic        ovf_clr,
  output logic [31:0] m_axis_event_tdata,
  output logic        m_axis_event_tvalid,
  input  logic        m_axis_event_tready,
  output logic        ovf
);

  import slope_trigger_pkg::*;

  trig_state_e       state;
  logic [15:0]       hold_cnt;
  logic [TS_W-1:0]   ts;
  logic signed [7:0] slope, hi, lo;
  logic              rise_hit, rearm, fire, pol;
  logic              fifo_full, fifo_empty, pop, drop;
  event_t            ev;

  assign slope    = signed'(signal_d);
  assign hi       = signed'(thr_hi);
  assign lo       = signed'(thr_lo);
  assign rise_hit = (slope >= hi);

`ifdef SLOPE_TRIGGER_NEG_EN
  logic fall_hit, pol_q;

  assign fall_hit = (slope <= sat_neg(hi));
  assign pol      = ~rise_hit & fall_hit;
  // Re-arm side follows the polarity of the event that disarmed us.
  assign rearm    = pol_q ? (slope >= sat_neg(lo)) : (slope <= lo);
  assign fire     = sample_valid & (state == ARMED) & (rise_hit | fall_hit);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)  pol_q <= 1'b0;
    else if (fire) pol_q <= pol;
  end
`else
  assign pol   = 1'b0;
  assign rearm = (slope <= lo);
  assign fire  = sample_valid & (state == ARMED) & rise_hit;
`endif

  assign ev = '{pol: pol, ts: ts, sig: signal, slope: signal_d};

  assign pop  = ~fifo_empty & m_axis_event_tready;
  assign drop = fire & fifo_full & ~pop;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ARMED;
      hold_cnt <= '0;
      ts       <= '0;
    end else if (sample_valid) begin
      ts <= ts + TS_W'(1);
      unique case (state)
        ARMED: if (fire) begin
          hold_cnt <= holdoff - 16'd1;
          state    <= (holdoff != 16'd0) ? HOLD : REARM;
        end
        // Counter holds holdoff-1 on entry, so exactly holdoff samples are ignored.
        HOLD:  if (hold_cnt == 16'd0) state <= REARM;
               else                   hold_cnt <= hold_cnt - 16'd1;
        REARM: if (rearm) state <= ARMED;
        default: state <= ARMED;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)     ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  slope_trigger_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .push    (fire),
    .din     (pack_event(ev)),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .tdata   (m_axis_event_tdata),
    .tvalid  (m_axis_event_tvalid),
    .tready  (m_axis_event_tready)
  );

endmodule
